// File: rtl/ro_trng_ctrl.sv
// Ring-oscillator TRNG sequencer: warm-up, parity-folded sampling, word packing and a
// repetition-count health test. Define TRNG_VON_NEUMANN_EN to debias the raw bit stream.
module ro_trng_ctrl #(
    parameter int RO_WIDTH   = 8,
    parameter int WORD_W     = 32,
    parameter int WARMUP_CYC = 64,
    parameter int SAMPLE_DIV = 4,
    parameter int RCT_LIMIT  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    output logic                ro_en,
    input  logic [RO_WIDTH-1:0] ro_data,
    output logic                rnd_valid,
    input  logic                rnd_ready,
    output logic [WORD_W-1:0]   rnd_data,
    output logic                busy,
    output logic                health_fail
);

    // Handshake: a word transfers on any clock edge where rnd_valid && rnd_ready; once
    // raised, rnd_valid and rnd_data hold until that transfer (stop may still abort it).

    localparam int WU_W  = $clog2(WARMUP_CYC + 1);
    localparam int DIV_W = $clog2(SAMPLE_DIV + 1);
    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam int RCT_W = $clog2(RCT_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_COLLECT,
        S_HOLD,
        S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [WU_W-1:0]    wu_cnt_q, wu_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [RCT_W-1:0]   rct_q, rct_d, rct_next;
    logic               prev_q, prev_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               sample_tick;
    logic               raw_bit;
    logic               emit_vld;
    logic               emit_bit;
    logic               run_d;

    assign sample_tick = (state_q == S_COLLECT) && (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign raw_bit     = ^ro_data;
    // A zero count means no sample yet since warm-up, so the first sample starts a run of 1.
    assign rct_next    = ((rct_q == '0) || (raw_bit != prev_q)) ? RCT_W'(1) : rct_q + 1'b1;

`ifdef TRNG_VON_NEUMANN_EN
    logic pair_q, pair_d;
    logic first_q, first_d;

    always_comb begin
        pair_d   = pair_q;
        first_d  = first_q;
        emit_vld = 1'b0;
        emit_bit = first_q;
        if (sample_tick) begin
            if (!pair_q) begin
                pair_d  = 1'b1;
                first_d = raw_bit;
            end else begin
                pair_d   = 1'b0;
                emit_vld = (first_q != raw_bit);
            end
        end
        if (state_q != S_COLLECT) pair_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            pair_q  <= pair_d;
            first_q <= first_d;
        end
    end
`else
    assign emit_vld = sample_tick;
    assign emit_bit = raw_bit;
`endif

    always_comb begin
        state_d   = state_q;
        wu_cnt_d  = wu_cnt_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        rct_d     = rct_q;
        prev_d    = prev_q;
        word_d    = word_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_WARMUP;
            S_WARMUP: begin
                if (wu_cnt_q == WU_W'(WARMUP_CYC - 1)) state_d = S_COLLECT;
                else wu_cnt_d = wu_cnt_q + 1'b1;
            end
            S_COLLECT: begin
                if (sample_tick) begin
                    div_d  = '0;
                    rct_d  = rct_next;
                    prev_d = raw_bit;
                    if (rct_next == RCT_W'(RCT_LIMIT)) begin
                        state_d = S_FAIL;
                    end else if (emit_vld) begin
                        word_d = {word_q[WORD_W-2:0], emit_bit};
                        if (bit_cnt_q == BIT_W'(WORD_W - 1)) state_d = S_HOLD;
                        else bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_HOLD: if (rnd_ready) state_d = S_COLLECT;
            S_FAIL: if (start) state_d = S_WARMUP;
            default: state_d = S_IDLE;
        endcase
        if (stop) state_d = S_IDLE;
        // Entry actions restart the per-phase counters; partial words die with bit_cnt.
        if ((state_d == S_WARMUP) && (state_q != S_WARMUP)) begin
            wu_cnt_d = '0;
            rct_d    = '0;
            prev_d   = 1'b0;
        end
        if ((state_d == S_COLLECT) && (state_q != S_COLLECT)) begin
            div_d     = '0;
            bit_cnt_d = '0;
        end
    end

    assign run_d    = (state_d == S_WARMUP) || (state_d == S_COLLECT) || (state_d == S_HOLD);
    assign rnd_data = word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wu_cnt_q    <= '0;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            rct_q       <= '0;
            prev_q      <= 1'b0;
            word_q      <= '0;
            ro_en       <= 1'b0;
            busy        <= 1'b0;
            rnd_valid   <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            state_q     <= state_d;
            wu_cnt_q    <= wu_cnt_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            rct_q       <= rct_d;
            prev_q      <= prev_d;
            word_q      <= word_d;
            ro_en       <= run_d;
            busy        <= run_d;
            rnd_valid   <= (state_d == S_HOLD);
            if (state_d == S_FAIL) health_fail <= 1'b1;
            else if ((state_d == S_WARMUP) && (state_q != S_WARMUP)) health_fail <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ro_trng_ctrl.sv
// Directed bench for ro_trng_ctrl: a bit-level model feeds an expected-word queue that is
// drained at every valid/ready transfer; optional Von Neumann build follows TRNG_VON_NEUMANN_EN.
module tb_ro_trng_ctrl;

    localparam int RO_WIDTH   = 8;
    localparam int WORD_W     = 8;
    localparam int WARMUP_CYC = 4;
    localparam int SAMPLE_DIV = 1;
    localparam int RCT_LIMIT  = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                stop;
    logic                ro_en;
    logic [RO_WIDTH-1:0] ro_data;
    logic                rnd_valid;
    logic                rnd_ready;
    logic [WORD_W-1:0]   rnd_data;
    logic                busy;
    logic                health_fail;

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0] exp_q[$];
    logic [WORD_W-1:0] exp_w;

    // Bench model state
    logic [WORD_W-1:0] m_word;
    logic [WORD_W-1:0] m_last;
    int                m_cnt;
    int                m_rct;
    logic              m_prev;
    logic              m_pair;
    logic              m_first;
    logic              m_fail;
    logic              word_done;

    ro_trng_ctrl #(
        .RO_WIDTH  (RO_WIDTH),
        .WORD_W    (WORD_W),
        .WARMUP_CYC(WARMUP_CYC),
        .SAMPLE_DIV(SAMPLE_DIV),
        .RCT_LIMIT (RCT_LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .ro_en      (ro_en),
        .ro_data    (ro_data),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_data   (rnd_data),
        .busy       (busy),
        .health_fail(health_fail)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every transfer consumes the oldest expected word
    always @(negedge clk) begin
        if (rst_n && rnd_valid && rnd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                assert (1'b0) else begin
                    errors++;
                    $error("FAIL word_unexpected got %0h required none", rnd_data);
                end
            end else begin
                exp_w = exp_q.pop_front();
                assert (rnd_data === exp_w) else begin
                    errors++;
                    $error("FAIL word got %0h required %0h", rnd_data, exp_w);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [RO_WIDTH-1:0] rand_with_parity(input logic p);
        logic [RO_WIDTH-1:0] r;
        r = RO_WIDTH'($urandom_range(0, (2 ** RO_WIDTH) - 1));
        if ((^r) != p) r[0] = ~r[0];
        return r;
    endfunction

    task automatic model_restart();
        m_cnt     = 0;
        m_rct     = 0;
        m_prev    = 1'b0;
        m_pair    = 1'b0;
        m_fail    = 1'b0;
        word_done = 1'b0;
    endtask

    task automatic emit(input logic b);
        m_word = {m_word[WORD_W-2:0], b};
        m_cnt++;
        if (m_cnt == WORD_W) begin
            exp_q.push_back(m_word);
            m_last    = m_word;
            m_cnt     = 0;
            word_done = 1'b1;
        end
    endtask

    task automatic model_push(input logic p);
        word_done = 1'b0;
        if ((m_rct == 0) || (p != m_prev)) m_rct = 1;
        else m_rct++;
        m_prev = p;
        if (m_rct == RCT_LIMIT) begin
            m_fail = 1'b1;
            return;
        end
`ifdef TRNG_VON_NEUMANN_EN
        if (!m_pair) begin
            m_first = p;
            m_pair  = 1'b1;
        end else begin
            m_pair = 1'b0;
            if (m_first != p) emit(m_first);
        end
`else
        emit(p);
`endif
    endtask

    // Driver: one sample with the requested parity, then the cycle-exact output checks
    task automatic do_sample(input logic p);
        ro_data = rand_with_parity(p);
        model_push(p);
        cyc(1);
        check("rnd_valid", rnd_valid, word_done);
        check("health_fail", health_fail, m_fail);
        check("ro_en", ro_en, !m_fail);
        if (word_done && rnd_ready) begin
            ro_data = rand_with_parity(1'($urandom_range(0, 1)));
            cyc(1);
            check("valid_drop", rnd_valid, 1'b0);
            m_pair = 1'b0;
        end
    endtask

    task automatic start_gen();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        model_restart();
        check("start_ro_en", ro_en, 1'b1);
        check("start_busy", busy, 1'b1);
        check("start_health", health_fail, 1'b0);
        cyc(WARMUP_CYC);
    endtask

    initial begin
        logic [7:0] pat;
        logic       p;
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        rnd_ready = 1'b1;
        ro_data   = '0;
        m_word    = '0;
        m_last    = '0;
        m_first   = 1'b0;
        model_restart();
        cyc(2);
        check("rst_ro_en", ro_en, 1'b0);
        check("rst_valid", rnd_valid, 1'b0);
        check("rst_data", rnd_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_health", health_fail, 1'b0);
        rst_n = 1'b1;
        cyc(1);

        // Nominal: parity 1,0,1,0,... from the first sample
        start_gen();
        for (int i = 0; i < 8; i++) do_sample(~i[0]);

        // Backpressure: word completes with ready low, then stays put for 10 cycles
        rnd_ready = 1'b0;
        word_done = 1'b0;
        for (int i = 0; i < 4 * WORD_W && !word_done; i++) begin
            p = 1'($urandom_range(0, 1));
            if ((m_rct >= RCT_LIMIT - 2) && (p == m_prev)) p = ~p;
            do_sample(p);
        end
        for (int i = 0; i < 10; i++) begin
            ro_data = rand_with_parity(1'($urandom_range(0, 1)));
            cyc(1);
            check("bp_valid", rnd_valid, 1'b1);
            check("bp_data", rnd_data, m_last);
            check("bp_ro_en", ro_en, 1'b1);
        end
        rnd_ready = 1'b1;
        cyc(1);
        check("bp_accept_drop", rnd_valid, 1'b0);
        m_pair = 1'b0;
        for (int i = 0; i < 8; i++) do_sample(i[0]);

        // Stop on the third COLLECT cycle, then start&&stop together in IDLE
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("stop_busy0", busy, 1'b0);
        start_gen();
        do_sample(1'b1);
        do_sample(1'b0);
        stop    = 1'b1;
        ro_data = rand_with_parity(1'b1);
        cyc(1);
        stop = 1'b0;
        check("stop_ro_en", ro_en, 1'b0);
        check("stop_busy", busy, 1'b0);
        check("stop_valid", rnd_valid, 1'b0);
        check("stop_health", health_fail, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", busy, 1'b0);
        check("ss_ro_en", ro_en, 1'b0);
        cyc(1);
        check("ss_busy_later", busy, 1'b0);

        // Health: constant parity 0 trips the repetition-count test on sample 16
        start_gen();
        for (int i = 0; i < 3 * RCT_LIMIT && !m_fail; i++) do_sample(1'b0);
        check("hf_model_reached", m_rct, RCT_LIMIT);
        cyc(2);
        check("hf_sticky", health_fail, 1'b1);
        check("hf_busy", busy, 1'b0);
        check("hf_valid", rnd_valid, 1'b0);
        check("hf_ro_en", ro_en, 1'b0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("hf_stop_keeps", health_fail, 1'b1);
        check("hf_stop_busy", busy, 1'b0);
        start_gen();

        // Stream 0,1,1,0,0,0,1,1 repeated four times
        pat = 8'b0110_0011;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 8; j++) do_sample(pat[7-j]);

        // Asynchronous reset mid-run
        for (int i = 0; i < 3; i++) do_sample(i[0]);
        rst_n = 1'b0;
        #1;
        check("arst_ro_en", ro_en, 1'b0);
        check("arst_valid", rnd_valid, 1'b0);
        check("arst_data", rnd_data, '0);
        check("arst_busy", busy, 1'b0);
        check("arst_health", health_fail, 1'b0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        check("arst_idle_busy", busy, 1'b0);
        check("arst_idle_ro_en", ro_en, 1'b0);

        check("words_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
